// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - shared op/state types for the flop bank controller
package dff_bank_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD   = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        PULSE = 3'd2,
        RECOV = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dff_bank_ctrl_rr_arb2.sv
// rtl/dff_bank_ctrl_rr_arb2.sv - two-way round-robin arbiter, pointer advanced on accept
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] win
);

    logic ptr;

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b10 : 2'b01;
            default: win = 2'b00;
        endcase
    end

    // After a grant the pointer favours the requester that did not win.
    always_ff @(posedge clk) begin
        if (!clr) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= win[0];
        end
    end

endmodule

// File: rtl/dff_bank_ctrl.sv
// rtl/dff_bank_ctrl.sv - arbitrated LOAD/SET/CLEAR/TOGGLE sequencer for an external flop bank
// Optional readback check: DFF_READBACK_CHECK_EN
module dff_bank_ctrl
    import dff_bank_pkg::*;
#(
    parameter int W         = 8,
    parameter int PULSE_CYC = 2
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      req,
    input  logic [OP_W-1:0] op0,
    input  logic [W-1:0]    arg0,
    input  logic [OP_W-1:0] op1,
    input  logic [W-1:0]    arg1,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic            busy,
    output logic [W-1:0]    bank_d,
    output logic [W-1:0]    bank_pre,
    output logic [W-1:0]    bank_clr,
    input  logic [W-1:0]    bank_q,
    output logic            err
);

    localparam int CW = $clog2(PULSE_CYC + 1);

    state_t          state, state_n;
    op_t             op_q, op_n, op_sel;
    logic [W-1:0]    arg_q, arg_n, arg_sel;
    logic [W-1:0]    shadow, shadow_n;
    logic [W-1:0]    pre_n, clrp_n;
    logic [1:0]      who, who_n, win, gnt_n, done_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            accept;

    function automatic logic [W-1:0] apply_op(op_t o, logic [W-1:0] s, logic [W-1:0] a);
        case (o)
            OP_LOAD:  return a;
            OP_SET:   return s | a;
            OP_CLEAR: return s & ~a;
            default:  return s ^ a;
        endcase
    endfunction

    assign accept  = ((state == IDLE) || (state == DONE)) && (req != 2'b00);
    assign op_sel  = win[1] ? op_t'(op1) : op_t'(op0);
    assign arg_sel = win[1] ? arg1 : arg0;
    assign bank_d  = shadow;

    rr_arb2 u_arb (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .accept (accept),
        .win    (win)
    );

    always_comb begin
        state_n  = state;
        op_n     = op_q;
        arg_n    = arg_q;
        who_n    = who;
        cnt_n    = cnt;
        shadow_n = shadow;
        gnt_n    = 2'b00;
        done_n   = 2'b00;
        pre_n    = '1;
        clrp_n   = '1;
        case (state)
            EXEC: begin
                state_n = DONE;
                done_n  = who;
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_n = RECOV;
                end else begin
                    cnt_n = cnt - 1'b1;
                    if (op_q == OP_SET) pre_n = ~arg_q;
                    else                clrp_n = ~arg_q;
                end
            end
            RECOV: begin
                state_n = DONE;
                done_n  = who;
            end
            DONE:    state_n = IDLE;
            default: ;
        endcase
        // DONE doubles as an accept slot so back-to-back commands lose no cycle.
        if (accept) begin
            op_n     = op_sel;
            arg_n    = arg_sel;
            who_n    = win;
            gnt_n    = win;
            shadow_n = apply_op(op_sel, shadow, arg_sel);
            cnt_n    = CW'(PULSE_CYC - 1);
            if ((op_sel == OP_LOAD) || (op_sel == OP_TOGGLE)) begin
                state_n = EXEC;
            end else begin
                state_n = PULSE;
                if (op_sel == OP_SET) pre_n = ~arg_sel;
                else                  clrp_n = ~arg_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            op_q     <= OP_LOAD;
            arg_q    <= '0;
            who      <= 2'b00;
            cnt      <= '0;
            shadow   <= '0;
            gnt      <= 2'b00;
            done     <= 2'b00;
            busy     <= 1'b0;
            bank_pre <= '1;
            bank_clr <= '0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            arg_q    <= arg_n;
            who      <= who_n;
            cnt      <= cnt_n;
            shadow   <= shadow_n;
            gnt      <= gnt_n;
            done     <= done_n;
            busy     <= (state_n != IDLE);
            bank_pre <= pre_n;
            bank_clr <= clrp_n;
        end
    end

`ifdef DFF_READBACK_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            err_q <= 1'b0;
        end else if ((state == DONE) && (bank_q != shadow)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_bank_q;

    assign unused_bank_q = ^bank_q;
    assign err           = 1'b0;
`endif

endmodule
